// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the alu and its arbiter front-end: operator codes,
// the arbiter FSM state encoding and an illegal-operator decode helper.
// ---------------------------------------------------------------------------
package alu_pkg;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_XOR  = 4'b0011;
   localparam logic [3:0] OP_NOR  = 4'b0100;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_SHL  = 4'b1000;
   localparam logic [3:0] OP_SHR  = 4'b1001;
   localparam logic [3:0] OP_SRA  = 4'b1010;
   localparam logic [3:0] OP_ADDS = 4'b1011;
   localparam logic [3:0] OP_SUBS = 4'b1100;
   localparam logic [3:0] OP_IDLE = 4'b1111;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StLoad = 2'b01,
      StExec = 2'b10,
      StResp = 2'b11
   } arb_state_e;

   // Codes the alu does not implement (1111 is the neutral idle code).
   function automatic logic op_is_illegal(input logic [3:0] op);
      return (op == 4'b0101) || (op == 4'b1101) || (op == 4'b1110) || (op == 4'b1111);
   endfunction

endpackage

// File: rtl/alu_rr_grant.sv
// ---------------------------------------------------------------------------
// alu_rr_grant
// Two-way round-robin grant: the requester named by i_pri wins when valid,
// otherwise the other requester wins when valid. Purely combinational.
// Ports:
//   i_valid[1:0]  request valid per requester
//   i_pri         preferred requester index
//   o_grant[1:0]  one-hot grant (all zero when nobody is valid)
// ---------------------------------------------------------------------------
module alu_rr_grant (
   input  logic [1:0] i_valid,
   input  logic       i_pri,
   output logic [1:0] o_grant
);

   always_comb begin
      o_grant = 2'b00;
      if (i_valid[i_pri]) begin
         o_grant[i_pri] = 1'b1;
      end else if (i_valid[~i_pri]) begin
         o_grant[~i_pri] = 1'b1;
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
// Shares one combinational alu between requester 0 (execute stage) and
// requester 1 (branch/compare unit). One operation at a time, round-robin
// priority. Operands are presented one cycle before the operator, and the
// operator returns to IDLE_OP between operations so the alu always sees an
// operator change. The result is captured and handed back with valid/ready.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   rN_req_valid/ready/op/a/b       request channel of requester N
//   rN_resp_valid/ready             response handshake of requester N
//   resp_ret/overflow/zero/illegal  captured response (shared)
//   alu_operator/operand0/operand1  to the alu
//   alu_ret/overflow/zero           from the alu
// ---------------------------------------------------------------------------
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int unsigned    WIDTH   = 32,
   parameter int unsigned    OPW     = 4,
   parameter logic [OPW-1:0] IDLE_OP = 4'b1111
) (
   input  logic             clk,
   input  logic             rst_n,

   input  logic             r0_req_valid,
   output logic             r0_req_ready,
   input  logic [OPW-1:0]   r0_req_op,
   input  logic [WIDTH-1:0] r0_req_a,
   input  logic [WIDTH-1:0] r0_req_b,
   output logic             r0_resp_valid,
   input  logic             r0_resp_ready,

   input  logic             r1_req_valid,
   output logic             r1_req_ready,
   input  logic [OPW-1:0]   r1_req_op,
   input  logic [WIDTH-1:0] r1_req_a,
   input  logic [WIDTH-1:0] r1_req_b,
   output logic             r1_resp_valid,
   input  logic             r1_resp_ready,

   output logic [WIDTH-1:0] resp_ret,
   output logic             resp_overflow,
   output logic             resp_zero,
   output logic             resp_illegal,

   output logic [OPW-1:0]   alu_operator,
   output logic [WIDTH-1:0] alu_operand0,
   output logic [WIDTH-1:0] alu_operand1,
   input  logic [WIDTH-1:0] alu_ret,
   input  logic             alu_overflow,
   input  logic             alu_zero
);

   arb_state_e       r_state;
   arb_state_e       w_state_next;

   logic [OPW-1:0]   r_op;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_owner;
   logic             r_pri;

   logic [WIDTH-1:0] r_ret;
   logic             r_ovf;
   logic             r_zero;
   logic             r_ill;

   logic [1:0]       w_grant;
   logic             w_accept;
   logic             w_owner_resp_ready;
   logic             w_illegal;

   alu_rr_grant u_grant (
      .i_valid ({r1_req_valid, r0_req_valid}),
      .i_pri   (r_pri),
      .o_grant (w_grant)
   );

   // rst_n gating keeps req_ready low while reset is held, even though the
   // reset state is IDLE.
   assign w_accept           = (r_state == StIdle) && rst_n && (w_grant != 2'b00);
   assign w_owner_resp_ready = r_owner ? r1_resp_ready : r0_resp_ready;
   assign w_illegal          = op_is_illegal(r_op);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle:  if (w_accept) w_state_next = StLoad;
         StLoad:  w_state_next = StExec;
         StExec:  w_state_next = StResp;
         StResp:  if (w_owner_resp_ready) w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   // Outputs
   always_comb begin
      r0_req_ready  = 1'b0;
      r1_req_ready  = 1'b0;
      r0_resp_valid = 1'b0;
      r1_resp_valid = 1'b0;
      alu_operator  = IDLE_OP;
      unique case (r_state)
         StIdle: begin
            r0_req_ready = w_grant[0] & rst_n;
            r1_req_ready = w_grant[1] & rst_n;
         end
         StLoad: begin
            alu_operator = IDLE_OP;
         end
         StExec: begin
            // Illegal codes never reach the alu.
            if (!w_illegal) alu_operator = r_op;
         end
         StResp: begin
            r0_resp_valid = ~r_owner;
            r1_resp_valid = r_owner;
         end
         default: begin
            alu_operator = IDLE_OP;
         end
      endcase
   end

   // Operands come straight from the latch, so they are stable from LOAD on.
   assign alu_operand0 = r_a;
   assign alu_operand1 = r_b;

   // Request latch, response capture and round-robin pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op    <= IDLE_OP;
         r_a     <= '0;
         r_b     <= '0;
         r_owner <= 1'b0;
         r_pri   <= 1'b0;
         r_ret   <= '0;
         r_ovf   <= 1'b0;
         r_zero  <= 1'b0;
         r_ill   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_owner <= w_grant[1];
            r_op    <= w_grant[1] ? r1_req_op : r0_req_op;
            r_a     <= w_grant[1] ? r1_req_a  : r0_req_a;
            r_b     <= w_grant[1] ? r1_req_b  : r0_req_b;
         end
         if (r_state == StExec) begin
            if (w_illegal) begin
               r_ret  <= '0;
               r_ovf  <= 1'b0;
               r_zero <= 1'b0;
               r_ill  <= 1'b1;
            end else begin
               r_ret  <= alu_ret;
               r_ovf  <= alu_overflow;
               r_zero <= alu_zero;
               r_ill  <= 1'b0;
            end
         end
         if ((r_state == StResp) && w_owner_resp_ready) begin
            r_pri <= ~r_owner;
         end
      end
   end

   assign resp_ret      = r_ret;
   assign resp_overflow = r_ovf;
   assign resp_zero     = r_zero;
   assign resp_illegal  = r_ill;

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
// Directed bench for alu_arbiter with a behavioural alu model. Expected
// responses are queued at issue time and checked by a separate monitor.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;
   import alu_pkg::*;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned OPW   = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             r0_req_valid = 1'b0, r1_req_valid = 1'b0;
   logic             r0_req_ready, r1_req_ready;
   logic [OPW-1:0]   r0_req_op = '0, r1_req_op = '0;
   logic [WIDTH-1:0] r0_req_a = '0, r0_req_b = '0, r1_req_a = '0, r1_req_b = '0;
   logic             r0_resp_valid, r1_resp_valid;
   logic             r0_resp_ready = 1'b1, r1_resp_ready = 1'b1;
   logic [WIDTH-1:0] resp_ret;
   logic             resp_overflow, resp_zero, resp_illegal;
   logic [OPW-1:0]   alu_operator;
   logic [WIDTH-1:0] alu_operand0, alu_operand1;
   logic [WIDTH-1:0] alu_ret;
   logic             alu_overflow, alu_zero;

   int n_checks = 0;
   int n_errors = 0;
   logic [35:0] sb_q[$];   // {owner, illegal, zero, overflow, ret}

   always #5 clk = ~clk;

   alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW), .IDLE_OP(4'b1111)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .r0_req_valid  (r0_req_valid),
      .r0_req_ready  (r0_req_ready),
      .r0_req_op     (r0_req_op),
      .r0_req_a      (r0_req_a),
      .r0_req_b      (r0_req_b),
      .r0_resp_valid (r0_resp_valid),
      .r0_resp_ready (r0_resp_ready),
      .r1_req_valid  (r1_req_valid),
      .r1_req_ready  (r1_req_ready),
      .r1_req_op     (r1_req_op),
      .r1_req_a      (r1_req_a),
      .r1_req_b      (r1_req_b),
      .r1_resp_valid (r1_resp_valid),
      .r1_resp_ready (r1_resp_ready),
      .resp_ret      (resp_ret),
      .resp_overflow (resp_overflow),
      .resp_zero     (resp_zero),
      .resp_illegal  (resp_illegal),
      .alu_operator  (alu_operator),
      .alu_operand0  (alu_operand0),
      .alu_operand1  (alu_operand1),
      .alu_ret       (alu_ret),
      .alu_overflow  (alu_overflow),
      .alu_zero      (alu_zero)
   );

   // Behavioural alu
   always_comb begin
      logic [WIDTH-1:0] a, b;
      a = alu_operand0;
      b = alu_operand1;
      alu_ret      = '0;
      alu_overflow = 1'b0;
      case (alu_operator)
         OP_AND:  alu_ret = a & b;
         OP_OR:   alu_ret = a | b;
         OP_ADD:  alu_ret = a + b;
         OP_XOR:  alu_ret = a ^ b;
         OP_NOR:  alu_ret = ~(a | b);
         OP_SUB:  alu_ret = a - b;
         OP_SLT:  alu_ret = {31'b0, ($signed(a) < $signed(b))};
         OP_SHL:  alu_ret = a << b[4:0];
         OP_SHR:  alu_ret = a >> b[4:0];
         OP_SRA:  alu_ret = $unsigned($signed(a) >>> b[4:0]);
         OP_ADDS: begin
            alu_ret      = a + b;
            alu_overflow = (a[31] == b[31]) && (alu_ret[31] != a[31]);
         end
         OP_SUBS: begin
            alu_ret      = a - b;
            alu_overflow = (a[31] != b[31]) && (alu_ret[31] != a[31]);
         end
         default: alu_ret = '0;
      endcase
      alu_zero = (alu_ret == '0);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [35:0] exp_resp(input logic owner, input logic ill, input logic zero,
                                            input logic ovf, input logic [31:0] ret);
      return {owner, ill, zero, ovf, ret};
   endfunction

   // Monitor: pops one expectation per consumed response.
   always @(negedge clk) begin
      if (rst_n && ((r0_resp_valid && r0_resp_ready) || (r1_resp_valid && r1_resp_ready))) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL resp_unexpected: got ret 0x%0h with empty queue at %0t", resp_ret,
                     $time);
         end else begin
            chk("resp", {r1_resp_valid, resp_illegal, resp_zero, resp_overflow, resp_ret},
                sb_q.pop_front());
         end
      end
   end

   task automatic set_req(input int r, input logic v, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b);
      if (r == 0) begin
         r0_req_valid = v; r0_req_op = op; r0_req_a = a; r0_req_b = b;
      end else begin
         r1_req_valid = v; r1_req_op = op; r1_req_a = a; r1_req_b = b;
      end
   endtask

   // Waits for any req_ready, checks which one, drops the accepted valid.
   task automatic wait_grant(input logic [1:0] exp_gnt, input string name, output int waited);
      logic [1:0] got;
      got    = 2'b00;
      waited = 0;
      while (got == 2'b00 && waited < 20) begin
         @(negedge clk);
         got = {r1_req_ready, r0_req_ready};
         waited++;
      end
      chk(name, got, exp_gnt);
      @(posedge clk);
      #1;
      if (got[0]) r0_req_valid = 1'b0;
      if (got[1]) r1_req_valid = 1'b0;
   endtask

   task automatic wait_drain();
      for (int n = 0; n < 60 && sb_q.size() != 0; n++) @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish at %0t", $time);
      $fatal(1);
   end

   initial begin
      int w;
      // Reset state
      #1;
      chk("rst_op", alu_operator, 4'hF);
      chk("rst_opnd", {alu_operand0, alu_operand1}, 0);
      chk("rst_resp", {resp_ret, resp_overflow, resp_zero, resp_illegal}, 0);
      chk("rst_hs", {r0_req_ready, r1_req_ready, r0_resp_valid, r1_resp_valid}, 0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;

      // 1: single ADD with latency and operator sequencing
      set_req(0, 1'b1, OP_ADD, 32'd5, 32'd7);
      sb_q.push_back(exp_resp(1'b0, 1'b0, 1'b0, 1'b0, 32'd12));
      wait_grant(2'b01, "t1_grant", w);
      @(negedge clk);
      chk("t1_load_op", alu_operator, 4'hF);
      chk("t1_load_a", alu_operand0, 32'd5);
      chk("t1_load_b", alu_operand1, 32'd7);
      chk("t1_load_rv", r0_resp_valid, 1'b0);
      @(negedge clk);
      chk("t1_exec_op", alu_operator, OP_ADD);
      chk("t1_exec_rv", r0_resp_valid, 1'b0);
      @(negedge clk);
      chk("t1_resp_rv", {r1_resp_valid, r0_resp_valid}, 2'b01);
      chk("t1_resp_op", alu_operator, 4'hF);
      wait_drain();

      // 2: contention after reset, then round-robin hands over to r1
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      set_req(0, 1'b1, OP_SUB, 32'd3, 32'd3);
      set_req(1, 1'b1, OP_OR, 32'd0, 32'd0);
      sb_q.push_back(exp_resp(1'b0, 1'b0, 1'b1, 1'b0, 32'd0));
      sb_q.push_back(exp_resp(1'b1, 1'b0, 1'b1, 1'b0, 32'd0));
      sb_q.push_back(exp_resp(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_00F0));
      wait_grant(2'b01, "t2_r0_first", w);
      set_req(0, 1'b1, OP_AND, 32'h0000_F0F0, 32'h0000_0FF0);
      wait_grant(2'b10, "t2_r1_next", w);
      wait_grant(2'b01, "t2_r0_last", w);
      wait_drain();

      // 3: back-to-back identical ADDS from r1, IDLE_OP in between
      set_req(1, 1'b1, OP_ADDS, 32'h7FFF_FFFF, 32'd1);
      sb_q.push_back(exp_resp(1'b1, 1'b0, 1'b0, 1'b1, 32'h8000_0000));
      sb_q.push_back(exp_resp(1'b1, 1'b0, 1'b0, 1'b1, 32'h8000_0000));
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk($sformatf("t3_op%0d", i), alu_operator, (i == 2 || i == 6) ? OP_ADDS : OP_IDLE);
         chk($sformatf("t3_rdy%0d", i), r1_req_ready, (i == 0 || i == 4));
         if (i == 4) begin
            @(posedge clk); #1;
            r1_req_valid = 1'b0;
         end
      end
      wait_drain();

      // 4: illegal operator
      set_req(0, 1'b1, 4'b0101, 32'd1, 32'd1);
      sb_q.push_back(exp_resp(1'b0, 1'b1, 1'b0, 1'b0, 32'd0));
      wait_grant(2'b01, "t4_grant", w);
      @(negedge clk);
      chk("t4_load_rv", r0_resp_valid, 1'b0);
      @(negedge clk);
      chk("t4_exec_rv", r0_resp_valid, 1'b0);
      @(negedge clk);
      chk("t4_resp_rv", r0_resp_valid, 1'b1);
      wait_drain();

      // 5: response backpressure blocks r1
      r0_resp_ready = 1'b0;
      set_req(0, 1'b1, OP_XOR, 32'h0000_00FF, 32'h0000_000F);
      sb_q.push_back(exp_resp(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_00F0));
      sb_q.push_back(exp_resp(1'b1, 1'b0, 1'b0, 1'b0, 32'd6));
      wait_grant(2'b01, "t5_grant_r0", w);
      set_req(1, 1'b1, OP_SUB, 32'd10, 32'd4);
      @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t5_hold_rv", r0_resp_valid, 1'b1);
         chk("t5_hold_r1rdy", r1_req_ready, 1'b0);
         chk("t5_hold_ret", resp_ret, 32'h0000_00F0);
      end
      @(posedge clk); #1;
      r0_resp_ready = 1'b1;
      @(posedge clk); #1;
      wait_grant(2'b10, "t5_grant_r1", w);
      chk("t5_r1_latency", w, 1);
      wait_drain();

      // 6: reset during EXEC
      set_req(0, 1'b1, OP_ADD, 32'd1, 32'd2);
      wait_grant(2'b01, "t6_grant", w);
      @(posedge clk); #1;
      chk("t6_in_exec", alu_operator, OP_ADD);
      rst_n = 1'b0;
      set_req(0, 1'b1, OP_AND, 32'h0000_00FF, 32'h0000_000F);
      set_req(1, 1'b1, OP_OR, 32'd1, 32'd2);
      #1;
      chk("t6_rst_hs", {r0_req_ready, r1_req_ready, r0_resp_valid, r1_resp_valid}, 0);
      chk("t6_rst_op", alu_operator, 4'hF);
      chk("t6_rst_resp", {resp_ret, resp_overflow, resp_zero, resp_illegal}, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      sb_q.push_back(exp_resp(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_000F));
      sb_q.push_back(exp_resp(1'b1, 1'b0, 1'b0, 1'b0, 32'd3));
      wait_grant(2'b01, "t6_r0_first", w);
      wait_grant(2'b10, "t6_r1_next", w);
      wait_drain();

      chk("drain", sb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
